// File: rtl/seg_scan_driver.sv
// Multiplexed hex display scanner: double-buffered value, one digit lit per refresh slot,
// updates committed only at frame boundaries, optional leading-zero blanking.
module seg_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [4*DIGITS-1:0]   wr_data,
  input  logic [DIGITS-1:0]     wr_dp,
  input  logic                  blank_lz,
  output logic                  wr_ack,
  output logic                  upd_pending,
  output logic [3:0]            nibble_out,
  output logic [DIGITS-1:0]     digit_en_n,
  output logic                  dp_n
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [DIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic [4*DIGITS-1:0] pend_q, pend_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                pend_valid_q, pend_valid_d;
  logic                ack_q;
  logic [3:0]          nib_q, nib_d;
  logic [DIGITS-1:0]   en_n_q, en_n_d;
  logic                dp_n_q, dp_n_d;

  logic                tick;
  logic                boundary;
  logic                zero_run;
  logic [DIGITS-1:0]   blank_vec;

  always_comb begin
    tick         = (cnt_q == LAST_CNT);
    boundary     = tick && (idx_q == LAST_IDX);
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    dp_sh_d      = dp_sh_q;
    pend_d       = pend_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;

    if (boundary) begin
      idx_d        = '0;
      pend_valid_d = 1'b0;
      // A write landing on the boundary edge goes straight to the shadow.
      if (wr_en) begin
        shadow_d = wr_data;
        dp_sh_d  = wr_dp;
      end else if (pend_valid_q) begin
        shadow_d = pend_q;
        dp_sh_d  = pend_dp_q;
      end
    end else begin
      if (tick) begin
        idx_d = idx_q + 1'b1;
      end
      if (wr_en) begin
        pend_d       = wr_data;
        pend_dp_d    = wr_dp;
        pend_valid_d = 1'b1;
      end
    end
  end

  // Blanking walks from the top digit down; a digit is blanked while everything above it is empty.
  always_comb begin
    zero_run  = 1'b1;
    blank_vec = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run && (shadow_d[4*i +: 4] == 4'h0) && !dp_sh_d[i];
      blank_vec[i] = blank_lz && zero_run && (i != 0);
    end
  end

  always_comb begin
    nib_d  = nib_q;
    en_n_d = en_n_q;
    dp_n_d = dp_n_q;
    if (tick) begin
      nib_d         = shadow_d[4*idx_d +: 4];
      dp_n_d        = ~dp_sh_d[idx_d];
      en_n_d        = '1;
      en_n_d[idx_d] = blank_vec[idx_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= LAST_IDX;
      shadow_q     <= '0;
      dp_sh_q      <= '0;
      pend_q       <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      ack_q        <= 1'b0;
      nib_q        <= 4'h0;
      en_n_q       <= '1;
      dp_n_q       <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      dp_sh_q      <= dp_sh_d;
      pend_q       <= pend_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      ack_q        <= wr_en;
      nib_q        <= nib_d;
      en_n_q       <= en_n_d;
      dp_n_q       <= dp_n_d;
    end
  end

  assign wr_ack      = ack_q;
  assign upd_pending = pend_valid_q;
  assign nibble_out  = nib_q;
  assign digit_en_n  = en_n_q;
  assign dp_n        = dp_n_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with DIGITS=4, REFRESH_DIV=4; cyc counts rising edges
// since the last reset release, and all sampling happens on the falling edge.
module tb_seg_scan_driver;

  localparam int DIGITS      = 4;
  localparam int REFRESH_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic [3:0]  wr_dp = '0;
  logic        blank_lz = 1'b0;
  logic        wr_ack;
  logic        upd_pending;
  logic [3:0]  nibble_out;
  logic [3:0]  digit_en_n;
  logic        dp_n;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  seg_scan_driver #(.DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .wr_dp(wr_dp),
    .blank_lz(blank_lz),
    .wr_ack(wr_ack),
    .upd_pending(upd_pending),
    .nibble_out(nibble_out),
    .digit_en_n(digit_en_n),
    .dp_n(dp_n)
  );

  always #5 clk = ~clk;

  task automatic go_to(input int c);
    while (cyc < c) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    int       at [5] = '{4, 8, 12, 16, 20};
    logic [3:0] en [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({digit_en_n, dp_n, nibble_out, wr_ack, upd_pending} !== {4'b1111, 1'b1, 4'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: en=%b dp_n=%b nib=%h ack=%b upd=%b expected en=1111 dp_n=1 nib=0 ack=0 upd=0",
               digit_en_n, dp_n, nibble_out, wr_ack, upd_pending);
    end
    rst_n = 1'b1;
    cyc = 0;
    go_to(3);
    checks++;
    if (digit_en_n !== 4'b1111) begin
      errors++;
      $display("FAIL dark_before_tick: en=%b expected 1111", digit_en_n);
    end
    for (int k = 0; k < 5; k++) begin
      go_to(at[k]);
      checks++;
      if ({digit_en_n, nibble_out, dp_n} !== {en[k], 4'h0, 1'b1}) begin
        errors++;
        $display("FAIL scan_order cyc=%0d: en=%b nib=%h dp_n=%b expected en=%b nib=0 dp_n=1",
                 cyc, digit_en_n, nibble_out, dp_n, en[k]);
      end
    end
  endtask

  task automatic test_write;
    int         at [4] = '{36, 40, 44, 48};
    logic [3:0] en [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] nb [4] = '{4'hF, 4'h2, 4'hA, 4'h1};
    logic       dn [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    go_to(22);
    wr_en = 1'b1; wr_data = 16'h1A2F; wr_dp = 4'b0100;
    go_to(23);
    wr_en = 1'b0;
    checks++;
    if ({wr_ack, upd_pending} !== 2'b11) begin
      errors++;
      $display("FAIL write_ack: ack=%b upd=%b expected ack=1 upd=1", wr_ack, upd_pending);
    end
    go_to(24);
    checks++;
    if ({wr_ack, upd_pending} !== 2'b01) begin
      errors++;
      $display("FAIL write_ack_one_cycle: ack=%b upd=%b expected ack=0 upd=1", wr_ack, upd_pending);
    end
    go_to(35);
    checks++;
    if ({upd_pending, digit_en_n, nibble_out} !== {1'b1, 4'b0111, 4'h0}) begin
      errors++;
      $display("FAIL write_held_until_frame: upd=%b en=%b nib=%h expected upd=1 en=0111 nib=0",
               upd_pending, digit_en_n, nibble_out);
    end
    for (int k = 0; k < 4; k++) begin
      go_to(at[k]);
      checks++;
      if ({digit_en_n, nibble_out, dp_n, upd_pending} !== {en[k], nb[k], dn[k], 1'b0}) begin
        errors++;
        $display("FAIL write_frame cyc=%0d: en=%b nib=%h dp_n=%b upd=%b expected en=%b nib=%h dp_n=%b upd=0",
                 cyc, digit_en_n, nibble_out, dp_n, upd_pending, en[k], nb[k], dn[k]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int         at [4] = '{52, 56, 60, 64};
    logic [3:0] en [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    wr_en = 1'b1; wr_data = 16'h1111; wr_dp = 4'b0000;
    go_to(49);
    wr_en = 1'b0;
    checks++;
    if (wr_ack !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_ack: ack=%b expected 1", wr_ack);
    end
    go_to(50);
    checks++;
    if (wr_ack !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ack_gap: ack=%b expected 0", wr_ack);
    end
    wr_en = 1'b1; wr_data = 16'h2222;
    go_to(51);
    wr_en = 1'b0;
    checks++;
    if ({wr_ack, upd_pending, digit_en_n, nibble_out} !== {1'b1, 1'b1, 4'b0111, 4'h1}) begin
      errors++;
      $display("FAIL b2b_second_ack: ack=%b upd=%b en=%b nib=%h expected ack=1 upd=1 en=0111 nib=1",
               wr_ack, upd_pending, digit_en_n, nibble_out);
    end
    for (int k = 0; k < 4; k++) begin
      go_to(at[k]);
      checks++;
      if ({digit_en_n, nibble_out, dp_n} !== {en[k], 4'h2, 1'b1}) begin
        errors++;
        $display("FAIL b2b_last_wins cyc=%0d: en=%b nib=%h dp_n=%b expected en=%b nib=2 dp_n=1",
                 cyc, digit_en_n, nibble_out, dp_n, en[k]);
      end
    end
  endtask

  task automatic test_boundary_write;
    int         at [3] = '{72, 76, 80};
    logic [3:0] en [3] = '{4'b1101, 4'b1011, 4'b0111};
    logic [3:0] nb [3] = '{4'hC, 4'h0, 4'h0};
    go_to(67);
    wr_en = 1'b1; wr_data = 16'h00C5; wr_dp = 4'b0000;
    go_to(68);
    wr_en = 1'b0;
    checks++;
    if ({digit_en_n, nibble_out, dp_n, upd_pending, wr_ack} !== {4'b1110, 4'h5, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL boundary_bypass: en=%b nib=%h dp_n=%b upd=%b ack=%b expected en=1110 nib=5 dp_n=1 upd=0 ack=1",
               digit_en_n, nibble_out, dp_n, upd_pending, wr_ack);
    end
    go_to(69);
    checks++;
    if ({wr_ack, upd_pending} !== 2'b00) begin
      errors++;
      $display("FAIL boundary_no_pending: ack=%b upd=%b expected ack=0 upd=0", wr_ack, upd_pending);
    end
    for (int k = 0; k < 3; k++) begin
      go_to(at[k]);
      checks++;
      if ({digit_en_n, nibble_out} !== {en[k], nb[k]}) begin
        errors++;
        $display("FAIL boundary_frame cyc=%0d: en=%b nib=%h expected en=%b nib=%h",
                 cyc, digit_en_n, nibble_out, en[k], nb[k]);
      end
    end
  endtask

  task automatic test_blank;
    int         at [13] = '{84, 88, 92, 96, 100, 104, 108, 112, 116, 132, 136, 140, 144};
    logic [3:0] en [13] = '{4'b1110, 4'b1101, 4'b1111, 4'b1111,
                            4'b1110, 4'b1111, 4'b1111, 4'b1111, 4'b1110,
                            4'b1110, 4'b1101, 4'b1011, 4'b1111};
    logic [3:0] nb [13] = '{4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                            4'h0, 4'h0, 4'h0, 4'h0};
    logic       dn [13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                            1'b1, 1'b1, 1'b0, 1'b1};
    blank_lz = 1'b1;
    wr_en = 1'b1; wr_data = 16'h0030; wr_dp = 4'b0000;
    go_to(81);
    wr_en = 1'b0;
    for (int k = 0; k < 13; k++) begin
      go_to(at[k]);
      checks++;
      if ({digit_en_n, nibble_out, dp_n} !== {en[k], nb[k], dn[k]}) begin
        errors++;
        $display("FAIL blank_lz cyc=%0d: en=%b nib=%h dp_n=%b expected en=%b nib=%h dp_n=%b",
                 cyc, digit_en_n, nibble_out, dp_n, en[k], nb[k], dn[k]);
      end
      if (cyc == 96) begin
        wr_en = 1'b1; wr_data = 16'h0000; wr_dp = 4'b0000;
        go_to(97);
        wr_en = 1'b0;
      end else if (cyc == 116) begin
        wr_en = 1'b1; wr_data = 16'h0000; wr_dp = 4'b0100;
        go_to(117);
        wr_en = 1'b0;
      end
    end
    blank_lz = 1'b0;
    go_to(160);
    checks++;
    if ({digit_en_n, nibble_out, dp_n} !== {4'b0111, 4'h0, 1'b1}) begin
      errors++;
      $display("FAIL blank_off_live: en=%b nib=%h dp_n=%b expected en=0111 nib=0 dp_n=1",
               digit_en_n, nibble_out, dp_n);
    end
  endtask

  task automatic test_reset_mid;
    int         at [5] = '{4, 8, 12, 16, 20};
    logic [3:0] en [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    go_to(172);
    checks++;
    if ({digit_en_n, dp_n} !== {4'b1011, 1'b0}) begin
      errors++;
      $display("FAIL pre_reset_digit2: en=%b dp_n=%b expected en=1011 dp_n=0", digit_en_n, dp_n);
    end
    wr_en = 1'b1; wr_data = 16'h9876; wr_dp = 4'b1111;
    go_to(173);
    wr_en = 1'b0;
    checks++;
    if (upd_pending !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_pending: upd=%b expected 1", upd_pending);
    end
    go_to(174);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({digit_en_n, dp_n, nibble_out, wr_ack, upd_pending} !== {4'b1111, 1'b1, 4'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: en=%b dp_n=%b nib=%h ack=%b upd=%b expected en=1111 dp_n=1 nib=0 ack=0 upd=0",
               digit_en_n, dp_n, nibble_out, wr_ack, upd_pending);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    for (int k = 0; k < 5; k++) begin
      go_to(at[k]);
      checks++;
      if ({digit_en_n, nibble_out, dp_n, upd_pending} !== {en[k], 4'h0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL post_reset cyc=%0d: en=%b nib=%h dp_n=%b upd=%b expected en=%b nib=0 dp_n=1 upd=0",
                 cyc, digit_en_n, nibble_out, dp_n, upd_pending, en[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_back_to_back();
    test_boundary_write();
    test_blank();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
